// File: rtl/clock_pkg.sv
// Shared definitions for the clock adjust path: state encoding, mode LED
// patterns, count direction and the field ring ordering.
// Optional feature macro: ALARM_ADJ_EN adds the alarm fields to the ring.
package clock_pkg;

    typedef enum logic [2:0] {
        CLOCK      = 3'd0,
        ADJ_HOUR   = 3'd1,
        ADJ_MIN    = 3'd2,
        ALARM_HOUR = 3'd3,
        ALARM_MIN  = 3'd4
    } adj_state_t;

    localparam logic [3:0] LED_CLOCK = 4'b0001;
    localparam logic [3:0] LED_HOUR  = 4'b0010;
    localparam logic [3:0] LED_MIN   = 4'b0100;
    localparam logic [3:0] LED_ALARM = 4'b1000;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Step to the next field to the right in the adjust ring.
    function automatic adj_state_t ring_next(adj_state_t s);
        case (s)
            ADJ_HOUR:   ring_next = ADJ_MIN;
`ifdef ALARM_ADJ_EN
            ADJ_MIN:    ring_next = ALARM_HOUR;
            ALARM_HOUR: ring_next = ALARM_MIN;
            ALARM_MIN:  ring_next = ADJ_HOUR;
`else
            ADJ_MIN:    ring_next = ADJ_HOUR;
`endif
            default:    ring_next = ADJ_HOUR;
        endcase
    endfunction

    // Step to the previous field (exact reverse of ring_next).
    function automatic adj_state_t ring_prev(adj_state_t s);
        case (s)
`ifdef ALARM_ADJ_EN
            ADJ_HOUR:   ring_prev = ALARM_MIN;
            ALARM_MIN:  ring_prev = ALARM_HOUR;
            ALARM_HOUR: ring_prev = ADJ_MIN;
`else
            ADJ_HOUR:   ring_prev = ADJ_MIN;
`endif
            ADJ_MIN:    ring_prev = ADJ_HOUR;
            default:    ring_prev = ADJ_HOUR;
        endcase
    endfunction

    function automatic logic is_hour(adj_state_t s);
        is_hour = (s == ADJ_HOUR) || (s == ALARM_HOUR);
    endfunction

    function automatic logic is_alarm(adj_state_t s);
        is_alarm = (s == ALARM_HOUR) || (s == ALARM_MIN);
    endfunction

    // LED pattern: one bit per field plus the alarm flag.
    function automatic logic [3:0] led_of(adj_state_t s);
        case (s)
            ADJ_HOUR, ALARM_HOUR: led_of = LED_HOUR;
            ADJ_MIN, ALARM_MIN:   led_of = LED_MIN;
            default:              led_of = LED_CLOCK;
        endcase
`ifdef ALARM_ADJ_EN
        if (is_alarm(s)) led_of = led_of | LED_ALARM;
`endif
    endfunction

endpackage

// File: rtl/time_adjust_ctrl_if.sv
// Button levels in, Time-block controls out.
interface time_adjust_ctrl_if;

    logic       btnC;
    logic       btnL;
    logic       btnR;
    logic       btnU;
    logic       btnD;
    logic       adjust;
    logic       ENTH;
    logic       ENTM;
    logic       updown;
    logic [3:0] mode_led;
    logic       alarm_sel;

    modport master (
        output btnC, btnL, btnR, btnU, btnD,
        input  adjust, ENTH, ENTM, updown, mode_led, alarm_sel
    );

    modport slave (
        input  btnC, btnL, btnR, btnU, btnD,
        output adjust, ENTH, ENTM, updown, mode_led, alarm_sel
    );

endinterface

// File: rtl/time_adjust_ctrl_btn_edge.sv
// Rising-edge detector for one debounced button level. The press output is
// registered; prev resets high so a button held through reset never fires.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    logic prev;

    // Track last sampled level and flag a 0->1 transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev  <= 1'b1;
            press <= 1'b0;
        end else begin
            prev  <= btn;
            press <= btn & ~prev;
        end
    end

endmodule

// File: rtl/time_adjust_ctrl.sv
// Mode controller feeding the Time counter: walks between run and
// per-field adjust modes and issues single-cycle step enables.
// Optional feature macro: ALARM_ADJ_EN (alarm fields in the adjust ring).
module time_adjust_ctrl
    import clock_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    time_adjust_ctrl_if.slave bus
);

    logic p_c, p_l, p_r, p_u, p_d;

    btn_edge u_edge_c (.clk(clk), .rst(rst), .btn(bus.btnC), .press(p_c));
    btn_edge u_edge_l (.clk(clk), .rst(rst), .btn(bus.btnL), .press(p_l));
    btn_edge u_edge_r (.clk(clk), .rst(rst), .btn(bus.btnR), .press(p_r));
    btn_edge u_edge_u (.clk(clk), .rst(rst), .btn(bus.btnU), .press(p_u));
    btn_edge u_edge_d (.clk(clk), .rst(rst), .btn(bus.btnD), .press(p_d));

    adj_state_t state_q, state_d;
    logic       enth_d, entm_d, updown_d;
    logic       adjust_q, enth_q, entm_q, updown_q;
    logic [3:0] led_q;

    // Next state and step pulses; C beats L/R beats U/D, losers are dropped.
    // L and R together cancel each other (field unchanged, U/D still dropped).
    always_comb begin
        state_d  = state_q;
        enth_d   = 1'b0;
        entm_d   = 1'b0;
        updown_d = updown_q;
        if (p_c) begin
            if (state_q == CLOCK) begin
                state_d = ADJ_HOUR;
            end else begin
                state_d  = CLOCK;
                updown_d = DIR_UP;
            end
        end else if (state_q != CLOCK) begin
            if (p_l | p_r) begin
                if (p_r & ~p_l)      state_d = ring_next(state_q);
                else if (p_l & ~p_r) state_d = ring_prev(state_q);
            end else if (p_u ^ p_d) begin
                updown_d = p_d ? DIR_DOWN : DIR_UP;
                if (is_hour(state_q)) enth_d = 1'b1;
                else                  entm_d = 1'b1;
            end
        end
    end

    // State and registered outputs, decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= CLOCK;
            adjust_q <= 1'b0;
            enth_q   <= 1'b0;
            entm_q   <= 1'b0;
            updown_q <= DIR_UP;
            led_q    <= LED_CLOCK;
        end else begin
            state_q  <= state_d;
            adjust_q <= (state_d != CLOCK);
            enth_q   <= enth_d;
            entm_q   <= entm_d;
            updown_q <= updown_d;
            led_q    <= led_of(state_d);
        end
    end

`ifdef ALARM_ADJ_EN
    logic alarm_q;

    // Alarm field select follows the state register.
    always_ff @(posedge clk) begin
        if (rst) alarm_q <= 1'b0;
        else     alarm_q <= is_alarm(state_d);
    end

    assign bus.alarm_sel = alarm_q;
`else
    assign bus.alarm_sel = 1'b0;
`endif

    assign bus.adjust   = adjust_q;
    assign bus.ENTH     = enth_q;
    assign bus.ENTM     = entm_q;
    assign bus.updown   = updown_q;
    assign bus.mode_led = led_q;

endmodule
